// File: rtl/mips_bus_arbiter_if.sv
// One mips_cpu_bus link: a master drives the request, a slave returns the handshake.
interface mips_bus_arbiter_if;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 4;

    logic [AW-1:0] address;
    logic          read;
    logic          write;
    logic [DW-1:0] writedata;
    logic [BW-1:0] byteenable;
    logic          waitrequest;
    logic [DW-1:0] readdata;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata
    );
endinterface

// File: rtl/mips_bus_arbiter.sv
// Two-master, one-slave round-robin arbiter with a per-transaction stall watchdog.
module mips_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [31:0] ABORT_READDATA = 32'hDEAD_BEEF
) (
    input  logic                clk,
    input  logic                reset,
    mips_bus_arbiter_if.slave   m0,
    mips_bus_arbiter_if.slave   m1,
    mips_bus_arbiter_if.master  s,
    output logic [1:0]          grant,
    output logic                timeout_error,
    input  logic                error_clear
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned AW    = 32;
    localparam int unsigned BW    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             last_q, last_d;       // master served last: 0 = m0, 1 = m1
    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
    logic             err_q, err_d;

    logic             req0, req1, busy, own1, abort, done;
    logic [AW-1:0]    sel_address, sel_writedata;
    logic [BW-1:0]    sel_byteenable;
    logic             sel_read, sel_write;

    assign req0  = m0.read | m0.write;
    assign req1  = m1.read | m1.write;
    assign busy  = (state_q != IDLE);
    assign own1  = (state_q == BUSY1);
    // Stalled for the full budget and still stalling: give up on this transaction.
    assign abort = busy & s.waitrequest & (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES));
    assign done  = busy & (~s.waitrequest | abort);

    // In IDLE the mux rests on m0; the slave strobes are gated off anyway.
    assign sel_address    = own1 ? m1.address    : m0.address;
    assign sel_writedata  = own1 ? m1.writedata  : m0.writedata;
    assign sel_byteenable = own1 ? m1.byteenable : m0.byteenable;
    assign sel_read       = own1 ? m1.read       : m0.read;
    assign sel_write      = own1 ? m1.write      : m0.write;

    // State, fairness pointer, watchdog and sticky error registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            wd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            wd_cnt_q <= wd_cnt_d;
            err_q    <= err_d;
        end
    end

    // Arbitration, handover and watchdog next-state.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        wd_cnt_d = wd_cnt_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                wd_cnt_d = '0;
                if (req0 && req1) begin
                    state_d = last_q ? BUSY0 : BUSY1;
                end else if (req0) begin
                    state_d = BUSY0;
                end else if (req1) begin
                    state_d = BUSY1;
                end
            end
            BUSY0: begin
                if (done) begin
                    last_d   = 1'b0;
                    wd_cnt_d = '0;
                    state_d  = req1 ? BUSY1 : IDLE;
                end else if (s.waitrequest) begin
                    wd_cnt_d = wd_cnt_q + CNT_W'(1);
                end
            end
            BUSY1: begin
                if (done) begin
                    last_d   = 1'b1;
                    wd_cnt_d = '0;
                    state_d  = req0 ? BUSY0 : IDLE;
                end else if (s.waitrequest) begin
                    wd_cnt_d = wd_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                wd_cnt_d = '0;
            end
        endcase
        if (error_clear) begin
            err_d = 1'b0;
        end else if (abort) begin
            err_d = 1'b1;
        end
    end

    // Slave forwarding and master handshake returns.
    always_comb begin
        s.address      = sel_address;
        s.writedata    = sel_writedata;
        s.byteenable   = sel_byteenable;
        s.write        = busy & sel_write & ~abort;
        s.read         = busy & sel_read & ~sel_write & ~abort;
        m0.waitrequest = 1'b1;
        m1.waitrequest = 1'b1;
        m0.readdata    = s.readdata;
        m1.readdata    = s.readdata;
        if (done) begin
            if (own1) begin
                m1.waitrequest = 1'b0;
                m1.readdata    = abort ? ABORT_READDATA : s.readdata;
            end else begin
                m0.waitrequest = 1'b0;
                m0.readdata    = abort ? ABORT_READDATA : s.readdata;
            end
        end
        grant         = {own1, (state_q == BUSY0)};
        timeout_error = err_q;
    end
endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Scenario tasks plus a randomized run checked against a transaction-level model.
module tb_mips_bus_arbiter;
    localparam int unsigned TO       = 4;
    localparam logic [31:0] ABORT_RD = 32'hDEAD_BEEF;

    logic       clk;
    logic       reset;
    logic       error_clear;
    logic [1:0] grant;
    logic       timeout_error;
    int         errors;
    int         checks;

    mips_bus_arbiter_if m0_if ();
    mips_bus_arbiter_if m1_if ();
    mips_bus_arbiter_if s_if ();

    mips_bus_arbiter #(
        .TIMEOUT_CYCLES (TO),
        .ABORT_READDATA (ABORT_RD)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .m0            (m0_if),
        .m1            (m1_if),
        .s             (s_if),
        .grant         (grant),
        .timeout_error (timeout_error),
        .error_clear   (error_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        m0_if.read = 1'b0; m0_if.write = 1'b0; m0_if.address = $urandom;
        m0_if.writedata = $urandom; m0_if.byteenable = 4'($urandom);
        m1_if.read = 1'b0; m1_if.write = 1'b0; m1_if.address = $urandom;
        m1_if.writedata = $urandom; m1_if.byteenable = 4'($urandom);
        s_if.waitrequest = 1'b0; s_if.readdata = $urandom;
        error_clear = 1'b0;
    endtask

    task automatic do_reset();
        quiet();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        quiet();
        reset = 1'b1;
        #2;
        for (int p = 0; p < 2; p++) begin
            checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got=%b exp=00", grant); end
            checks++; if (s_if.read !== 1'b0 || s_if.write !== 1'b0) begin errors++; $display("FAIL reset_strobes got r=%b w=%b exp 0/0", s_if.read, s_if.write); end
            checks++; if (m0_if.waitrequest !== 1'b1 || m1_if.waitrequest !== 1'b1) begin errors++; $display("FAIL reset_wait got m0=%b m1=%b exp 1/1", m0_if.waitrequest, m1_if.waitrequest); end
            checks++; if (timeout_error !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", timeout_error); end
            tick();
            @(negedge clk);
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        logic [31:0] a;
        do_reset();
        a = $urandom;
        m0_if.address = a; m0_if.read = 1'b1;
        s_if.waitrequest = 1'b0; s_if.readdata = 32'h1234_5678;
        @(negedge clk);
        checks++; if (grant !== 2'b00 || s_if.read !== 1'b0) begin errors++; $display("FAIL single_pre got grant=%b s_read=%b exp 00/0", grant, s_if.read); end
        tick();
        @(negedge clk);
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL single_grant got=%b exp=01", grant); end
        checks++; if (s_if.read !== 1'b1 || s_if.address !== a) begin errors++; $display("FAIL single_fwd got r=%b a=%h exp 1/%h", s_if.read, s_if.address, a); end
        checks++; if (m0_if.waitrequest !== 1'b0 || m0_if.readdata !== 32'h1234_5678) begin errors++; $display("FAIL single_done got w=%b rd=%h exp 0/12345678", m0_if.waitrequest, m0_if.readdata); end
        tick();
        m0_if.read = 1'b0;
        @(negedge clk);
        checks++; if (grant !== 2'b00 || s_if.read !== 1'b0 || m0_if.waitrequest !== 1'b1) begin errors++; $display("FAIL single_post got grant=%b r=%b w=%b exp 00/0/1", grant, s_if.read, m0_if.waitrequest); end
    endtask

    task automatic test_tie_writes();
        logic [31:0] a0, a1, d0, d1;
        logic [1:0]  eg;
        do_reset();
        a0 = $urandom; a1 = $urandom; d0 = $urandom; d1 = $urandom;
        m0_if.address = a0; m0_if.writedata = d0; m0_if.write = 1'b1;
        m1_if.address = a1; m1_if.writedata = d1; m1_if.write = 1'b1;
        tick();
        for (int i = 1; i <= 9; i++) begin
            s_if.waitrequest = !(i == 4 || i == 8);
            @(negedge clk);
            eg = (i <= 4) ? 2'b01 : ((i <= 8) ? 2'b10 : 2'b00);
            checks++; if (grant !== eg) begin errors++; $display("FAIL tie_grant c%0d got=%b exp=%b", i, grant, eg); end
            checks++; if (s_if.write !== (i <= 8)) begin errors++; $display("FAIL tie_swrite c%0d got=%b exp=%b", i, s_if.write, (i <= 8)); end
            checks++; if (m0_if.waitrequest !== (i != 4) || m1_if.waitrequest !== (i != 8)) begin errors++; $display("FAIL tie_wait c%0d got m0=%b m1=%b", i, m0_if.waitrequest, m1_if.waitrequest); end
            if (i <= 8) begin
                checks++; if (s_if.address !== ((i <= 4) ? a0 : a1) || s_if.writedata !== ((i <= 4) ? d0 : d1)) begin errors++; $display("FAIL tie_fwd c%0d got a=%h d=%h", i, s_if.address, s_if.writedata); end
            end
            tick();
            if (i == 4) m0_if.write = 1'b0;
            if (i == 8) m1_if.write = 1'b0;
        end
        // m1 served last, so a fresh tie goes to m0.
        m0_if.write = 1'b1; m1_if.write = 1'b1;
        tick();
        @(negedge clk);
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL tie_pointer got=%b exp=01", grant); end
    endtask

    task automatic test_back_to_back();
        int n_done;
        int prev;
        int who;
        do_reset();
        m0_if.read = 1'b1; m1_if.read = 1'b1;
        n_done = 0;
        prev = 1;
        tick();
        for (int c = 0; c < 200 && n_done < 10; c++) begin
            s_if.waitrequest = bit'($urandom_range(0, 1));
            s_if.readdata = $urandom;
            @(negedge clk);
            checks++; if (grant !== 2'b01 && grant !== 2'b10) begin errors++; $display("FAIL b2b_bubble c%0d got grant=%b exp one-hot", c, grant); end
            who = (m0_if.waitrequest === 1'b0) ? 0 : ((m1_if.waitrequest === 1'b0) ? 1 : -1);
            if (who >= 0) begin
                checks++; if (who == prev) begin errors++; $display("FAIL b2b_alternate txn%0d got master=%0d exp=%0d", n_done, who, 1 - prev); end
                checks++; if (grant !== ((who == 0) ? 2'b01 : 2'b10)) begin errors++; $display("FAIL b2b_grant txn%0d got=%b master=%0d", n_done, grant, who); end
                prev = who;
                n_done++;
            end
            tick();
            if (who == 0) m0_if.address = $urandom;
            if (who == 1) m1_if.address = $urandom;
        end
        checks++; if (n_done != 10) begin errors++; $display("FAIL b2b_budget got=%0d completions exp=10", n_done); end
    endtask

    task automatic test_timeout();
        do_reset();
        m1_if.read = 1'b1; m1_if.address = $urandom;
        s_if.waitrequest = 1'b1;
        tick();
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            checks++; if (grant !== 2'b10) begin errors++; $display("FAIL to_grant c%0d got=%b exp=10", i, grant); end
            checks++; if (s_if.read !== (i < 5) || m1_if.waitrequest !== (i < 5)) begin errors++; $display("FAIL to_cycle c%0d got r=%b w=%b exp %b", i, s_if.read, m1_if.waitrequest, (i < 5)); end
            checks++; if (timeout_error !== 1'b0) begin errors++; $display("FAIL to_err_early c%0d got=%b exp=0", i, timeout_error); end
            if (i == 5) begin
                checks++; if (m1_if.readdata !== ABORT_RD) begin errors++; $display("FAIL to_readdata got=%h exp=%h", m1_if.readdata, ABORT_RD); end
            end
            tick();
        end
        m1_if.read = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (timeout_error !== 1'b1 || grant !== 2'b00) begin errors++; $display("FAIL to_sticky c%0d got err=%b grant=%b exp 1/00", i, timeout_error, grant); end
            tick();
        end
        error_clear = 1'b1;
        tick();
        error_clear = 1'b0;
        @(negedge clk);
        checks++; if (timeout_error !== 1'b0) begin errors++; $display("FAIL to_clear got=%b exp=0", timeout_error); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        m0_if.read = 1'b1; s_if.waitrequest = 1'b1;
        tick();
        tick();
        #2;
        checks++; if (s_if.read !== 1'b1) begin errors++; $display("FAIL rmid_pre got s_read=%b exp=1", s_if.read); end
        reset = 1'b1;
        #1;
        checks++; if (s_if.read !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL rmid_drop got r=%b grant=%b exp 0/00", s_if.read, grant); end
        checks++; if (m0_if.waitrequest !== 1'b1 || m1_if.waitrequest !== 1'b1 || timeout_error !== 1'b0) begin errors++; $display("FAIL rmid_hs got w0=%b w1=%b err=%b exp 1/1/0", m0_if.waitrequest, m1_if.waitrequest, timeout_error); end
        m0_if.read = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_rw_both();
        logic [31:0] wd;
        logic [3:0]  be;
        do_reset();
        wd = $urandom; be = 4'($urandom);
        m0_if.read = 1'b1; m0_if.write = 1'b1; m0_if.writedata = wd; m0_if.byteenable = be;
        s_if.waitrequest = 1'b1;
        tick();
        @(negedge clk);
        checks++; if (s_if.write !== 1'b1 || s_if.read !== 1'b0) begin errors++; $display("FAIL rw_strobes got r=%b w=%b exp 0/1", s_if.read, s_if.write); end
        checks++; if (s_if.writedata !== wd || s_if.byteenable !== be) begin errors++; $display("FAIL rw_data got d=%h be=%h exp %h/%h", s_if.writedata, s_if.byteenable, wd, be); end
        do_reset();
    endtask

    task automatic test_random();
        logic        r [2], w [2], act [2];
        logic [31:0] a [2], d [2];
        logic [3:0]  b [2];
        logic        ow [2];
        logic [31:0] ord [2];
        logic        stall_mode;
        int          owner, last, stall;
        bit          err, busy, abrt, dn, ereq, ewr;
        logic [1:0]  eg;
        logic [31:0] erd;
        do_reset();
        owner = -1; last = 1; stall = 0; err = 1'b0; stall_mode = 1'b0;
        for (int k = 0; k < 2; k++) begin r[k] = 0; w[k] = 0; act[k] = 0; a[k] = 0; d[k] = 0; b[k] = 0; end
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (!act[k] && $urandom_range(0, 3) == 0) begin
                    int kind;
                    kind = $urandom_range(0, 2);
                    act[k] = 1'b1;
                    r[k] = (kind != 1); w[k] = (kind != 0);
                    a[k] = $urandom; d[k] = $urandom; b[k] = 4'($urandom);
                end
            end
            m0_if.read = r[0]; m0_if.write = w[0]; m0_if.address = a[0]; m0_if.writedata = d[0]; m0_if.byteenable = b[0];
            m1_if.read = r[1]; m1_if.write = w[1]; m1_if.address = a[1]; m1_if.writedata = d[1]; m1_if.byteenable = b[1];
            if ($urandom_range(0, 14) == 0) stall_mode = !stall_mode;
            s_if.waitrequest = stall_mode ? 1'b1 : ($urandom_range(0, 2) == 0);
            s_if.readdata = $urandom;
            error_clear = ($urandom_range(0, 19) == 0);
            @(negedge clk);
            busy = (owner >= 0);
            abrt = busy && s_if.waitrequest && (stall == TO);
            dn   = busy && (!s_if.waitrequest || abrt);
            eg   = (owner == 0) ? 2'b01 : ((owner == 1) ? 2'b10 : 2'b00);
            ewr  = busy && w[owner] && !abrt;
            ereq = busy && r[owner] && !w[owner] && !abrt;
            checks++; if (grant !== eg) begin errors++; $display("FAIL rnd_grant c%0d got=%b exp=%b", c, grant, eg); end
            checks++; if (s_if.write !== ewr || s_if.read !== ereq) begin errors++; $display("FAIL rnd_strobes c%0d got r=%b w=%b exp %b/%b", c, s_if.read, s_if.write, ereq, ewr); end
            checks++; if (timeout_error !== err) begin errors++; $display("FAIL rnd_err c%0d got=%b exp=%b", c, timeout_error, err); end
            if (busy) begin
                checks++; if (s_if.address !== a[owner] || s_if.writedata !== d[owner] || s_if.byteenable !== b[owner]) begin errors++; $display("FAIL rnd_fwd c%0d got a=%h d=%h be=%h", c, s_if.address, s_if.writedata, s_if.byteenable); end
            end
            ow[0] = m0_if.waitrequest; ow[1] = m1_if.waitrequest;
            ord[0] = m0_if.readdata;   ord[1] = m1_if.readdata;
            for (int k = 0; k < 2; k++) begin
                checks++; if (ow[k] !== !(dn && owner == k)) begin errors++; $display("FAIL rnd_wait c%0d m%0d got=%b exp=%b", c, k, ow[k], !(dn && owner == k)); end
                if (dn && owner == k) begin
                    erd = abrt ? ABORT_RD : s_if.readdata;
                    checks++; if (ord[k] !== erd) begin errors++; $display("FAIL rnd_rdata c%0d m%0d got=%h exp=%h", c, k, ord[k], erd); end
                end
            end
            // Model: fair pick from idle, handover to the other master on completion.
            if (owner < 0) begin
                if ((r[0] | w[0]) && (r[1] | w[1])) owner = 1 - last;
                else if (r[0] | w[0]) owner = 0;
                else if (r[1] | w[1]) owner = 1;
                stall = 0;
            end else if (dn) begin
                last = owner;
                owner = (r[1 - last] | w[1 - last]) ? (1 - last) : -1;
                stall = 0;
            end else if (s_if.waitrequest) begin
                stall++;
            end
            if (error_clear) err = 1'b0;
            else if (abrt) err = 1'b1;
            tick();
            for (int k = 0; k < 2; k++) begin
                if (ow[k] === 1'b0) begin act[k] = 1'b0; r[k] = 1'b0; w[k] = 1'b0; end
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset = 1'b1;
        test_reset();
        test_single_read();
        test_tie_writes();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_rw_both();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mips_bus_arbiter.md
# mips_bus_arbiter

Two-master, one-slave arbiter for the `mips_cpu_bus` memory interface (32-bit address, read/write strobes, byteenable, waitrequest handshake). It lets a second bus master, such as a debug loader or DMA engine, share the memory bus with the CPU. It sits between the masters and the memory/region-decode logic. Grants are registered with round-robin fairness, and a watchdog aborts any transaction the slave stalls for too long.

## Interface
Parameters:
- TIMEOUT_CYCLES, 64: slave waitrequest-high cycles tolerated per transaction before abort (>= 1).
- ABORT_READDATA, 32'hDEAD_BEEF: readdata returned to a master on an aborted transaction.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- m0_address / m1_address  in  32  master address.
- m0_read / m1_read  in  1  read request; held until waitrequest is seen low.
- m0_write / m1_write  in  1  write request; held until waitrequest is seen low.
- m0_writedata / m1_writedata  in  32  write data.
- m0_byteenable / m1_byteenable  in  4  byte lanes.
- m0_waitrequest / m1_waitrequest  out  1  low only in that master's completion cycle.
- m0_readdata / m1_readdata  out  32  read data, valid in the completion cycle.
- s_address  out  32  forwarded address.
- s_read / s_write  out  1  forwarded strobes.
- s_writedata  out  32  forwarded write data.
- s_byteenable  out  4  forwarded byte lanes.
- s_waitrequest  in  1  slave stall.
- s_readdata  in  32  slave read data.
- grant  out  2  one-hot owner: bit0 = m0, bit1 = m1; 2'b00 when idle.
- timeout_error  out  1  sticky abort flag.
- error_clear  in  1  synchronous clear of timeout_error.

## Operation
States:
- IDLE: no owner.
- BUSY0: m0 owns the bus.
- BUSY1: m1 owns the bus.

Request and arbitration:
- A master is requesting when `mX_read | mX_write` is high.
- In IDLE, the arbiter samples requests at the clock edge.
  - If one master requests, move to its BUSY state.
  - If both request, grant the master that was not served last. The last-served pointer resets to m1, so m0 wins the first tie.

Forwarding in BUSYx:
- Slave outputs come combinationally from master x.
- If master x asserts read and write together, write wins and s_read is forced to 0.

Completion:
- Completion occurs in a BUSYx cycle with `s_waitrequest == 0`.
- In that cycle, mx_waitrequest = 0 and mx_readdata = s_readdata. The last-served pointer updates to x.

Handover after completion:
- If the other master is requesting, go directly to its BUSY state with no bubble.
- Otherwise go to IDLE.
- The completing master is never re-granted from its stale request. It must pass through IDLE first.

Watchdog:
- A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to BUSY.
- It increments on every BUSY cycle with s_waitrequest = 1.
- When the counter equals TIMEOUT_CYCLES and s_waitrequest is still 1, that cycle is an abort cycle:
  - s_read and s_write are forced to 0.
  - mx_waitrequest = 0 and mx_readdata = ABORT_READDATA.
  - timeout_error is set at the edge.
  - Next state follows the normal completion/handover rule.

Outputs while not granted:
- The non-granted master sees waitrequest = 1.
- Its readdata equals s_readdata, which is don't-care.
- In IDLE, s_read = s_write = 0. s_address, s_writedata and s_byteenable carry m0's values (don't-care).

Error flag:
- error_clear wins over a simultaneous set; the flag reads 0 after that edge.

## Timing
Reset values:
- State IDLE, grant 2'b00.
- s_read = s_write = 0.
- m0_waitrequest = m1_waitrequest = 1.
- timeout_error = 0, counter 0.

Reset behaviour:
- Reset mid-transaction drops s_read and s_write immediately (asynchronous). No completion is signalled.

Latency:
- Request first visible at edge N: owner from edge N, slave strobes asserted in cycle N+1.
- With a zero-wait slave, completion is in cycle N+1, so master request-to-done is 2 cycles.
- A back-to-back handover adds 0 idle cycles.

Abort timing:
- An aborted transaction completes in BUSY cycle TIMEOUT_CYCLES+1 (slave stalled every cycle).

Handshake rule:
- Masters must hold address, data and strobes stable until they see their waitrequest low. The arbiter does not latch them.

## Test plan
- Single read, m0 only, slave zero-wait, s_readdata = 32'h1234_5678 → s_read high for exactly 1 cycle; m0_waitrequest low in that cycle; m0_readdata = 32'h1234_5678; grant 01 then 00.
- Simultaneous m0/m1 writes from reset, slave 3 wait cycles each → m0 is served first; m1 is granted on the cycle after m0 completes with no IDLE cycle; s_write stays continuously high for 8 cycles; pointer = m1.
- Both masters issue continuous back-to-back requests for 10 transactions → grants strictly alternate 01, 10, 01, …; neither master is served twice in a row.
- Slave holds waitrequest high forever, TIMEOUT_CYCLES = 4, m1 reads → abort in BUSY cycle 5; m1_readdata = 32'hDEAD_BEEF; s_read drops; timeout_error rises and stays set until error_clear, then reads 0.
- Assert reset while in BUSY0 with the slave stalling → s_read falls in the same cycle without waiting for an edge; grant = 00; both master waitrequests = 1; timeout_error = 0.
- m0 asserts read and write together → s_write = 1, s_read = 0, and writedata/byteenable are forwarded unchanged.
